ex_ctrl: RTL and testbench

- Exception/interrupt commit controller at the WB end of the 5-stage MIPS pipeline.
- Consumes per-instruction exception flags travelling with the WB instruction, plus CP0 Status/Cause/EPC.
- Decides whether the WB instruction commits, traps or erets, and drives the trap signals into the CP0 register file (wb_ex, excode, badvaddr, bd, pc).
- Raises a pipeline flush and hands a redirect PC to fetch through a valid/ready handshake.

---
 rtl/ex_ctrl_if.sv | 60 ++++++
 rtl/ex_ctrl.sv | 143 ++++++++++++++
 tb/tb_ex_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_ctrl_if
// Description : Bundle of WB-stage exception flags, CP0 state, trap outputs
//               to CP0 and the redirect valid/ready handshake to fetch.
//   master : the pipeline/CP0/fetch side (drives wb_*, c0_*, redirect_ready)
//   slave  : ex_ctrl (drives ex_*, eret_flush, wb_commit, flush, redirect_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_ctrl_if #(
  parameter int EXC_W = 5
);
  // WB-stage instruction
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic             wb_bd;
  logic             wb_adel_if;
  logic             wb_ri;
  logic             wb_sys;
  logic             wb_bp;
  logic             wb_ov;
  logic             wb_adel_mem;
  logic             wb_ades;
  logic [31:0]      wb_mem_addr;
  logic             wb_eret;
  // CP0 state
  logic [31:0]      c0_status;
  logic [31:0]      c0_cause;
  logic [31:0]      c0_epc;
  // Trap report to CP0
  logic             ex_valid;
  logic [EXC_W-1:0] ex_excode;
  logic [31:0]      ex_badvaddr;
  logic             ex_bd;
  logic [31:0]      ex_pc;
  logic             eret_flush;
  // Pipeline control and fetch redirect
  logic             wb_commit;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;

  modport master (
    output wb_valid, wb_pc, wb_bd, wb_adel_if, wb_ri, wb_sys, wb_bp, wb_ov,
           wb_adel_mem, wb_ades, wb_mem_addr, wb_eret,
           c0_status, c0_cause, c0_epc, redirect_ready,
    input  ex_valid, ex_excode, ex_badvaddr, ex_bd, ex_pc, eret_flush,
           wb_commit, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_pc, wb_bd, wb_adel_if, wb_ri, wb_sys, wb_bp, wb_ov,
           wb_adel_mem, wb_ades, wb_mem_addr, wb_eret,
           c0_status, c0_cause, c0_epc, redirect_ready,
    output ex_valid, ex_excode, ex_badvaddr, ex_bd, ex_pc, eret_flush,
           wb_commit, flush, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_ctrl
// Description : Exception/interrupt commit controller at the WB end of the
//               MIPS pipeline. Decides commit / trap / eret for the WB
//               instruction, reports traps to CP0, flushes the pipeline and
//               hands a redirect PC to fetch over a valid/ready handshake.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - ex_ctrl_if.slave (WB flags, CP0 state, trap outputs,
//                      flush/commit, redirect handshake)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_ctrl #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
  parameter int          EXC_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  ex_ctrl_if.slave    bus
);

  localparam logic [EXC_W-1:0] EXC_INT  = EXC_W'(5'h00);
  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(5'h04);
  localparam logic [EXC_W-1:0] EXC_ADES = EXC_W'(5'h05);
  localparam logic [EXC_W-1:0] EXC_SYS  = EXC_W'(5'h08);
  localparam logic [EXC_W-1:0] EXC_BP   = EXC_W'(5'h09);
  localparam logic [EXC_W-1:0] EXC_RI   = EXC_W'(5'h0a);
  localparam logic [EXC_W-1:0] EXC_OV   = EXC_W'(5'h0c);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        int_pending_q, int_pending_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic             any_flag;
  logic             in_idle;
  logic             trap;
  logic             eret_ok;
  logic             normal_ok;
  logic             in_redir;
  logic [EXC_W-1:0] trap_code;
  logic [31:0]      trap_bad;

  // Only IE, EXL, IM and IP are architecturally relevant here.
  logic unused_cp0;
  assign unused_cp0 = ^{bus.c0_status[31:16], bus.c0_status[7:2],
                        bus.c0_cause[31:16], bus.c0_cause[7:0]};

  assign int_pending_d = bus.c0_status[0] & ~bus.c0_status[1] &
                         (|(bus.c0_status[15:8] & bus.c0_cause[15:8]));

  assign any_flag = bus.wb_adel_if | bus.wb_ri | bus.wb_sys | bus.wb_bp |
                    bus.wb_ov | bus.wb_adel_mem | bus.wb_ades;

  // Every decision is gated by ~rst so that all outputs read 0 for the whole
  // reset assertion, not just after the flops have cleared.
  assign in_idle   = ~rst & (state_q == S_IDLE);
  assign in_redir  = ~rst & (state_q == S_REDIRECT);
  assign trap      = in_idle & bus.wb_valid & (int_pending_q | any_flag);
  assign eret_ok   = in_idle & bus.wb_valid & bus.wb_eret & ~trap;
  assign normal_ok = in_idle & bus.wb_valid & ~trap & ~bus.wb_eret;

  // Trap cause priority: interrupt first, then fetch-side faults before
  // execute-side and memory-side faults (program order within the insn).
  always_comb begin
    trap_code = EXC_INT;
    trap_bad  = 32'h0;
    if (int_pending_q) begin
      trap_code = EXC_INT;
    end else if (bus.wb_adel_if) begin
      trap_code = EXC_ADEL;
      trap_bad  = bus.wb_pc;
    end else if (bus.wb_ri) begin
      trap_code = EXC_RI;
    end else if (bus.wb_sys) begin
      trap_code = EXC_SYS;
    end else if (bus.wb_bp) begin
      trap_code = EXC_BP;
    end else if (bus.wb_ov) begin
      trap_code = EXC_OV;
    end else if (bus.wb_adel_mem) begin
      trap_code = EXC_ADEL;
      trap_bad  = bus.wb_mem_addr;
    end else if (bus.wb_ades) begin
      trap_code = EXC_ADES;
      trap_bad  = bus.wb_mem_addr;
    end
  end

  // Next state: one trap/eret is accepted, then WB is ignored until fetch
  // has taken the redirect target.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (trap) begin
          state_d       = S_REDIRECT;
          redirect_pc_d = EX_ENTRY;
        end else if (eret_ok) begin
          state_d       = S_REDIRECT;
          redirect_pc_d = bus.c0_epc;  // pre-update EPC
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      int_pending_q <= 1'b0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.ex_valid       = trap;
  assign bus.ex_excode      = trap ? trap_code : '0;
  assign bus.ex_badvaddr    = trap ? trap_bad : 32'h0;
  assign bus.ex_bd          = trap & bus.wb_bd;
  assign bus.ex_pc          = trap ? bus.wb_pc : 32'h0;
  assign bus.eret_flush     = eret_ok;
  assign bus.wb_commit      = eret_ok | normal_ok;
  assign bus.flush          = trap | eret_ok | in_redir;
  assign bus.redirect_valid = in_redir;
  assign bus.redirect_pc    = rst ? 32'h0 : redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_ctrl
// Description : Self-checking bench for ex_ctrl: table of single-instruction
//               vectors plus directed sequences for the redirect hold and
//               reset-in-REDIRECT cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  ex_ctrl_if #(.EXC_W(5)) bus ();

  ex_ctrl #(.EX_ENTRY(32'hbfc00380), .EXC_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: [6]=adel_if [5]=ri [4]=sys [3]=bp [2]=ov [1]=adel_mem [0]=ades
  typedef struct {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  flags;
    logic [31:0] maddr;
    logic        eret;
    logic        e_exv;
    logic [4:0]  e_code;
    logic [31:0] e_bad;
    logic        e_bd;
    logic [31:0] e_pc;
    logic        e_eret;
    logic        e_commit;
    logic        e_flush;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_wb(input logic v, input logic [31:0] pc, input logic bd,
                        input logic [6:0] fl, input logic [31:0] ma, input logic er);
    bus.wb_valid    = v;
    bus.wb_pc       = pc;
    bus.wb_bd       = bd;
    bus.wb_adel_if  = fl[6];
    bus.wb_ri       = fl[5];
    bus.wb_sys      = fl[4];
    bus.wb_bp       = fl[3];
    bus.wb_ov       = fl[2];
    bus.wb_adel_mem = fl[1];
    bus.wb_ades     = fl[0];
    bus.wb_mem_addr = ma;
    bus.wb_eret     = er;
  endtask

  task automatic set_c0(input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    bus.c0_status = st;
    bus.c0_cause  = ca;
    bus.c0_epc    = ep;
  endtask

  // Leave REDIRECT: one ready cycle (flush must still be high), then IDLE.
  task automatic drain(input string nm);
    set_wb(1'b0, 32'h0, 1'b0, 7'h0, 32'h0, 1'b0);
    bus.redirect_ready = 1'b1;
    #1 chk({nm, " flush@ready"}, {31'h0, bus.flush}, 32'h1);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1 chk({nm, " rv_after_ready"}, {31'h0, bus.redirect_valid}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    set_c0(v.status, v.cause, v.epc);
    set_wb(1'b0, 32'h0, 1'b0, 7'h0, 32'h0, 1'b0);
    bus.redirect_ready = 1'b0;
    @(negedge clk);  // int_pending now reflects this CP0 state
    set_wb(v.valid, v.pc, v.bd, v.flags, v.maddr, v.eret);
    #1;
    chk({nm, " ex_valid"},   {31'h0, bus.ex_valid},   {31'h0, v.e_exv});
    chk({nm, " excode"},     {27'h0, bus.ex_excode},  {27'h0, v.e_code});
    chk({nm, " badvaddr"},   bus.ex_badvaddr,         v.e_bad);
    chk({nm, " ex_bd"},      {31'h0, bus.ex_bd},      {31'h0, v.e_bd});
    chk({nm, " ex_pc"},      bus.ex_pc,               v.e_pc);
    chk({nm, " eret_flush"}, {31'h0, bus.eret_flush}, {31'h0, v.e_eret});
    chk({nm, " wb_commit"},  {31'h0, bus.wb_commit},  {31'h0, v.e_commit});
    chk({nm, " flush"},      {31'h0, bus.flush},      {31'h0, v.e_flush});
    @(negedge clk);
    #1;
    chk({nm, " redirect_valid"}, {31'h0, bus.redirect_valid}, {31'h0, v.e_redir});
    if (v.e_redir) begin
      chk({nm, " redirect_pc"},  bus.redirect_pc,             v.e_rpc);
      chk({nm, " redir flush"},  {31'h0, bus.flush},          32'h1);
      chk({nm, " redir ex_valid"}, {31'h0, bus.ex_valid},     32'h0);
      chk({nm, " redir commit"}, {31'h0, bus.wb_commit},      32'h0);
      drain(nm);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    //             status        cause         epc           v  pc            bd flags        maddr         er | exv code   bad           bd pc            eret cmt fl rd rpc
    vt[0]  = '{32'h0000ff01, 32'h00000400, 32'h0,        1, 32'hbfc01000, 0, 7'b0000000, 32'h0,        0,   1, 5'h00, 32'h0,        0, 32'hbfc01000, 0, 0, 1, 1, 32'hbfc00380};
    vt[1]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00000003, 0, 7'b1000100, 32'h0,        0,   1, 5'h04, 32'h00000003, 0, 32'h00000003, 0, 0, 1, 1, 32'hbfc00380};
    vt[2]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400010, 1, 7'b0000001, 32'h80000102, 0,   1, 5'h05, 32'h80000102, 1, 32'h00400010, 0, 0, 1, 1, 32'hbfc00380};
    vt[3]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400020, 0, 7'b0110000, 32'h0,        0,   1, 5'h0a, 32'h0,        0, 32'h00400020, 0, 0, 1, 1, 32'hbfc00380};
    vt[4]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400024, 0, 7'b0011000, 32'h0,        0,   1, 5'h08, 32'h0,        0, 32'h00400024, 0, 0, 1, 1, 32'hbfc00380};
    vt[5]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400028, 0, 7'b0001100, 32'h0,        0,   1, 5'h09, 32'h0,        0, 32'h00400028, 0, 0, 1, 1, 32'hbfc00380};
    vt[6]  = '{32'h0,        32'h0,        32'h0,        1, 32'h0040002c, 0, 7'b0000100, 32'h0,        0,   1, 5'h0c, 32'h0,        0, 32'h0040002c, 0, 0, 1, 1, 32'hbfc00380};
    vt[7]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400030, 0, 7'b0000011, 32'h00001001, 0,   1, 5'h04, 32'h00001001, 0, 32'h00400030, 0, 0, 1, 1, 32'hbfc00380};
    vt[8]  = '{32'h0,        32'h0,        32'h0,        1, 32'h00400034, 0, 7'b0000000, 32'hdeadbeef, 0,   0, 5'h00, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h0};
    vt[9]  = '{32'h0,        32'h0,        32'h0,        0, 32'h00400038, 0, 7'b0010000, 32'h0,        0,   0, 5'h00, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0};
    vt[10] = '{32'h0000ff03, 32'h00000400, 32'h0,        1, 32'h0040003c, 0, 7'b0000000, 32'h0,        0,   0, 5'h00, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h0};
    vt[11] = '{32'h0000ff01, 32'h00000400, 32'h11110000, 1, 32'h00400040, 0, 7'b0000000, 32'h0,        1,   1, 5'h00, 32'h0,        0, 32'h00400040, 0, 0, 1, 1, 32'hbfc00380};
    vt[12] = '{32'h0,        32'h0,        32'h22220000, 1, 32'h00400044, 0, 7'b0100000, 32'h0,        1,   1, 5'h0a, 32'h0,        0, 32'h00400044, 0, 0, 1, 1, 32'hbfc00380};
    vt[13] = '{32'h0,        32'h0,        32'h12345678, 1, 32'h00400048, 0, 7'b0000000, 32'h0,        1,   0, 5'h00, 32'h0,        0, 32'h0,        1, 1, 1, 1, 32'h12345678};
    vt[14] = '{32'h0000ff00, 32'h00000400, 32'h0,        1, 32'h0040004c, 0, 7'b0000000, 32'h0,        0,   0, 5'h00, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h0};
    vt[15] = '{32'h00000401, 32'h00000800, 32'h0,        1, 32'h00400050, 0, 7'b0000000, 32'h0,        0,   0, 5'h00, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h0};

    // Reset: outputs must read 0 even with a trapping instruction at WB.
    rst = 1'b1;
    bus.redirect_ready = 1'b0;
    set_c0(32'h0000ff01, 32'h00000400, 32'h0);
    set_wb(1'b1, 32'h00400000, 1'b1, 7'b0010000, 32'h0, 1'b0);
    #1;
    chk("rst ex_valid",  {31'h0, bus.ex_valid},       32'h0);
    chk("rst commit",    {31'h0, bus.wb_commit},      32'h0);
    chk("rst flush",     {31'h0, bus.flush},          32'h0);
    chk("rst rv",        {31'h0, bus.redirect_valid}, 32'h0);
    chk("rst rpc",       bus.redirect_pc,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_wb(1'b0, 32'h0, 1'b0, 7'h0, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) run_vec(vt[i], i);

    // eret, then redirect held off for 3 cycles with wrong-path syscall at WB.
    @(negedge clk);
    set_c0(32'h0, 32'h0, 32'hbfc00a00);
    @(negedge clk);
    set_wb(1'b1, 32'h00400100, 1'b0, 7'h0, 32'h0, 1'b1);
    #1;
    chk("er eret_flush", {31'h0, bus.eret_flush}, 32'h1);
    chk("er commit",     {31'h0, bus.wb_commit},  32'h1);
    chk("er flush",      {31'h0, bus.flush},      32'h1);
    chk("er ex_valid",   {31'h0, bus.ex_valid},   32'h0);
    @(negedge clk);
    bus.c0_epc = 32'h0badf00d;  // EPC change after eret must not leak through
    set_wb(1'b1, 32'h00400104, 1'b0, 7'b0010000, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold%0d rv", k),       {31'h0, bus.redirect_valid}, 32'h1);
      chk($sformatf("hold%0d flush", k),    {31'h0, bus.flush},          32'h1);
      chk($sformatf("hold%0d ex_valid", k), {31'h0, bus.ex_valid},       32'h0);
      chk($sformatf("hold%0d commit", k),   {31'h0, bus.wb_commit},      32'h0);
      chk($sformatf("hold%0d rpc", k),      bus.redirect_pc,             32'hbfc00a00);
      @(negedge clk);
    end
    bus.redirect_ready = 1'b1;
    #1;
    chk("hold ready rv",    {31'h0, bus.redirect_valid}, 32'h1);
    chk("hold ready flush", {31'h0, bus.flush},          32'h1);
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    #1;
    chk("post rv",       {31'h0, bus.redirect_valid}, 32'h0);
    chk("post ex_valid", {31'h0, bus.ex_valid},       32'h1);
    chk("post excode",   {27'h0, bus.ex_excode},      32'h08);
    @(negedge clk);
    drain("post");

    // Reset asserted while in REDIRECT with an interrupt pending.
    @(negedge clk);
    set_c0(32'h0000ff01, 32'h00000400, 32'h0);
    set_wb(1'b0, 32'h0, 1'b0, 7'h0, 32'h0, 1'b0);
    @(negedge clk);
    set_wb(1'b1, 32'h00400200, 1'b0, 7'h0, 32'h0, 1'b0);
    #1 chk("rr int trap", {31'h0, bus.ex_valid}, 32'h1);
    @(negedge clk);
    #1 chk("rr in redir", {31'h0, bus.redirect_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rr rv",       {31'h0, bus.redirect_valid}, 32'h0);
    chk("rr flush",    {31'h0, bus.flush},          32'h0);
    chk("rr rpc",      bus.redirect_pc,             32'h0);
    chk("rr ex_valid", {31'h0, bus.ex_valid},       32'h0);
    chk("rr commit",   {31'h0, bus.wb_commit},      32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_wb(1'b1, 32'h00400204, 1'b0, 7'h0, 32'h0, 1'b0);
    #1;
    chk("rel ex_valid", {31'h0, bus.ex_valid},       32'h0);
    chk("rel commit",   {31'h0, bus.wb_commit},      32'h1);
    chk("rel flush",    {31'h0, bus.flush},          32'h0);
    chk("rel rv",       {31'h0, bus.redirect_valid}, 32'h0);
    @(negedge clk);
    #1;
    chk("rel int back", {31'h0, bus.ex_valid}, 32'h1);
    @(negedge clk);
    drain("rel");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
